// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed 32-bit data memory behind a valid/ready
// request/response handshake with configurable access latency, MIPS-style
// sub-word loads/stores and misalignment detection.
// Optional feature macro: MEM_STATS_EN (adds rd_count/wr_count statistics).
module data_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
`ifdef MEM_STATS_EN
  ,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
`endif
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  // Reject parameter values the countdown and counters cannot represent.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("data_mem_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [31:0]         wdata_q;
  logic                resp_valid_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [31:0]         mem_q [DEPTH];

  logic [ADDR_W-3:0]   word_idx;
  logic [31:0]         word_rd;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic                acc_err;
  logic                commit;
  logic [31:0]         load_d;
  logic [31:0]         store_d;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign word_idx  = addr_q[ADDR_W-1:2];
  assign word_rd   = mem_q[word_idx];
  assign lane_byte = word_rd[{addr_q[1:0], 3'b000} +: 8];
  assign lane_half = addr_q[1] ? word_rd[31:16] : word_rd[15:0];

  // Illegal size, or a half/word that is not naturally aligned.
  assign acc_err = (size_q == 2'b11) ||
                   (size_q == 2'b01 && addr_q[0]) ||
                   (size_q == 2'b10 && addr_q[1:0] != 2'b00);

  // The last WAIT cycle is where stores write and loads sample the array.
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

  // Select the addressed lane(s) and zero- or sign-extend for sub-word loads.
  always_comb begin
    load_d = word_rd;
    case (size_q)
      2'b00:   load_d = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
      2'b01:   load_d = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
      default: load_d = word_rd;
    endcase
  end

  // Merge store data into the current word so untouched lanes keep their value.
  always_comb begin
    store_d = word_rd;
    case (size_q)
      2'b00:   store_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_d = wdata_q;
    endcase
  end

  // Storage array: written only at a good store's commit edge, never reset.
  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err) begin
      mem_q[word_idx] <= store_d;
    end
  end

  // Request/response FSM: accept in IDLE, count down in WAIT, hold in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            cnt_q    <= 4'(LATENCY - 1);
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            err_q        <= acc_err;
            rdata_q      <= (acc_err || we_q) ? 32'd0 : load_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic [CNT_W-1:0] rd_count_q;
  logic [CNT_W-1:0] wr_count_q;

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

  // Count good loads and stores at their commit edge; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (commit && !acc_err) begin
      if (we_q) begin
        wr_count_q <= wr_count_q + CNT_W'(1);
      end else begin
        rd_count_q <= rd_count_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: two instances (LATENCY=1, CNT_W=16 and
// LATENCY=3, CNT_W=2) driven by directed vectors with hand-computed results.
// Build with MEM_STATS_EN defined to also exercise the statistics counters.
module tb_data_mem_ctrl;

  localparam int NDUT = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } op_t;

  logic        clk;
  logic        rst_n      [NDUT];
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_we     [NDUT];
  logic [7:0]  req_addr   [NDUT];
  logic [1:0]  req_size   [NDUT];
  logic        req_signed [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        resp_valid [NDUT];
  logic        resp_ready [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];

  int vecCount;
  int missCount;
  int latOf [NDUT];

`ifdef MEM_STATS_EN
  logic [15:0] rdCount0, wrCount0;
  logic [1:0]  rdCount1, wrCount1;
`endif

  data_mem_ctrl #(.ADDR_W(8), .LATENCY(LAT0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
`ifdef MEM_STATS_EN
    , .rd_count(rdCount0), .wr_count(wrCount0)
`endif
  );

  data_mem_ctrl #(.ADDR_W(8), .LATENCY(LAT1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
`ifdef MEM_STATS_EN
    , .rd_count(rdCount1), .wr_count(wrCount1)
`endif
  );

  // Free-running clock shared by both instances.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on instance s and wait until its response is presented.
  task automatic start_req(input int s, input op_t op, output int edges);
    int n;
    n = 0;
    req_we[s]     = op.we;
    req_addr[s]   = op.addr;
    req_size[s]   = op.size;
    req_signed[s] = op.sgn;
    req_wdata[s]  = op.wdata;
    req_valid[s]  = 1'b1;
    while (!req_ready[s] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    edges = 0;
    while (!resp_valid[s] && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    if (!resp_valid[s]) begin
      vecCount++; missCount++;
      $display("[TB] FAIL resp_timeout dut%0d got resp_valid=0 want 1", s);
    end
  endtask

  // Complete the response handshake on instance s.
  task automatic finish_req(input int s);
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
  endtask

  // Reset instance s and confirm the idle output values.
  task automatic test_reset(input int s);
    rst_n[s] = 1'b0;
    @(posedge clk); #1;
    vecCount += 4;
    if (req_ready[s] !== 1'b1) begin missCount++; $display("[TB] FAIL rst_req_ready dut%0d got %b want 1", s, req_ready[s]); end
    if (resp_valid[s] !== 1'b0) begin missCount++; $display("[TB] FAIL rst_resp_valid dut%0d got %b want 0", s, resp_valid[s]); end
    if (resp_rdata[s] !== 32'd0) begin missCount++; $display("[TB] FAIL rst_rdata dut%0d got %h want 0", s, resp_rdata[s]); end
    if (resp_err[s] !== 1'b0) begin missCount++; $display("[TB] FAIL rst_err dut%0d got %b want 0", s, resp_err[s]); end
    @(posedge clk); #1;
    rst_n[s] = 1'b1;
    @(posedge clk); #1;
  endtask

  // Word store then load on both latencies, also checking response timing.
  task automatic test_word_rw();
    op_t ops[2] = '{
      '{1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0}
    };
    int edges;
    for (int s = 0; s < NDUT; s++) begin
      for (int i = 0; i < 2; i++) begin
        start_req(s, ops[i], edges);
        vecCount += 3;
        if (edges !== latOf[s]) begin missCount++; $display("[TB] FAIL word_latency dut%0d op%0d got %0d want %0d", s, i, edges, latOf[s]); end
        if (resp_rdata[s] !== ops[i].expData) begin missCount++; $display("[TB] FAIL word_rdata dut%0d op%0d got %h want %h", s, i, resp_rdata[s], ops[i].expData); end
        if (resp_err[s] !== ops[i].expErr) begin missCount++; $display("[TB] FAIL word_err dut%0d op%0d got %b want %b", s, i, resp_err[s], ops[i].expErr); end
        finish_req(s);
      end
    end
  endtask

  // Byte/half stores and signed/unsigned loads on dut0 (word 0x10 = DEADBEEF).
  task automatic test_subword();
    op_t ops[10] = '{
      '{1'b1, 8'h11, 2'b00, 1'b0, 32'h00000080, 32'h0,        1'b0},
      '{1'b0, 8'h11, 2'b00, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0},
      '{1'b0, 8'h11, 2'b00, 1'b0, 32'h0,        32'h00000080, 1'b0},
      '{1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0},
      '{1'b1, 8'h12, 2'b01, 1'b0, 32'hFFFF8001, 32'h0,        1'b0},
      '{1'b0, 8'h12, 2'b01, 1'b1, 32'h0,        32'hFFFF8001, 1'b0},
      '{1'b0, 8'h12, 2'b01, 1'b0, 32'h0,        32'h00008001, 1'b0},
      '{1'b0, 8'h10, 2'b10, 1'b1, 32'h0,        32'h800180EF, 1'b0},
      '{1'b0, 8'h13, 2'b00, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0},
      '{1'b0, 8'h10, 2'b00, 1'b0, 32'h0,        32'h000000EF, 1'b0}
    };
    int edges;
    for (int i = 0; i < 10; i++) begin
      start_req(0, ops[i], edges);
      vecCount += 2;
      if (resp_rdata[0] !== ops[i].expData) begin missCount++; $display("[TB] FAIL subword_rdata op%0d got %h want %h", i, resp_rdata[0], ops[i].expData); end
      if (resp_err[0] !== ops[i].expErr) begin missCount++; $display("[TB] FAIL subword_err op%0d got %b want %b", i, resp_err[0], ops[i].expErr); end
      finish_req(0);
    end
  endtask

  // Misaligned and illegal-size accesses flag an error and leave memory intact.
  task automatic test_misaligned();
    op_t ops[6] = '{
      '{1'b0, 8'h13, 2'b01, 1'b1, 32'h0,        32'h0,        1'b1},
      '{1'b1, 8'h12, 2'b10, 1'b0, 32'h12345678, 32'h0,        1'b1},
      '{1'b1, 8'h11, 2'b01, 1'b0, 32'h0000BEEF, 32'h0,        1'b1},
      '{1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        32'h800180EF, 1'b0},
      '{1'b0, 8'h10, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1},
      '{1'b1, 8'h10, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1}
    };
    int edges;
    for (int i = 0; i < 6; i++) begin
      start_req(0, ops[i], edges);
      vecCount += 2;
      if (resp_rdata[0] !== ops[i].expData) begin missCount++; $display("[TB] FAIL misalign_rdata op%0d got %h want %h", i, resp_rdata[0], ops[i].expData); end
      if (resp_err[0] !== ops[i].expErr) begin missCount++; $display("[TB] FAIL misalign_err op%0d got %b want %b", i, resp_err[0], ops[i].expErr); end
      finish_req(0);
    end
  endtask

  // Response held under backpressure while a toggling request is ignored.
  task automatic test_backpressure();
    op_t ld = '{1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'h800180EF, 1'b0};
    int edges;
    start_req(0, ld, edges);
    req_we[0]    = 1'b1;
    req_size[0]  = 2'b10;
    req_addr[0]  = 8'h10;
    req_wdata[0] = 32'h00000000;
    for (int c = 0; c < 5; c++) begin
      req_valid[0] = ~req_valid[0];
      @(posedge clk); #1;
      vecCount += 4;
      if (resp_valid[0] !== 1'b1) begin missCount++; $display("[TB] FAIL hold_valid cyc%0d got %b want 1", c, resp_valid[0]); end
      if (resp_rdata[0] !== 32'h800180EF) begin missCount++; $display("[TB] FAIL hold_rdata cyc%0d got %h want 800180ef", c, resp_rdata[0]); end
      if (resp_err[0] !== 1'b0) begin missCount++; $display("[TB] FAIL hold_err cyc%0d got %b want 0", c, resp_err[0]); end
      if (req_ready[0] !== 1'b0) begin missCount++; $display("[TB] FAIL hold_req_ready cyc%0d got %b want 0", c, req_ready[0]); end
    end
    req_valid[0] = 1'b0;
    finish_req(0);
    vecCount += 2;
    if (req_ready[0] !== 1'b1) begin missCount++; $display("[TB] FAIL release_req_ready got %b want 1", req_ready[0]); end
    if (resp_valid[0] !== 1'b0) begin missCount++; $display("[TB] FAIL release_resp_valid got %b want 0", resp_valid[0]); end
    repeat (3) begin @(posedge clk); #1; end
    vecCount++;
    if (resp_valid[0] !== 1'b0) begin missCount++; $display("[TB] FAIL stray_resp got %b want 0", resp_valid[0]); end
    start_req(0, ld, edges);
    vecCount++;
    if (resp_rdata[0] !== 32'h800180EF) begin missCount++; $display("[TB] FAIL ignored_store_mem got %h want 800180ef", resp_rdata[0]); end
    finish_req(0);
  endtask

  // Reset during WAIT on the LATENCY=3 instance discards the pending store.
  task automatic test_reset_midop();
    op_t sOld = '{1'b1, 8'h20, 2'b10, 1'b0, 32'h11111111, 32'h0, 1'b0};
    op_t ld   = '{1'b0, 8'h20, 2'b10, 1'b0, 32'h0, 32'h11111111, 1'b0};
    int edges;
    start_req(1, sOld, edges);
    finish_req(1);
    req_we[1]    = 1'b1;
    req_addr[1]  = 8'h20;
    req_size[1]  = 2'b10;
    req_signed[1] = 1'b0;
    req_wdata[1] = 32'hAAAAAAAA;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    vecCount++;
    if (req_ready[1] !== 1'b0) begin missCount++; $display("[TB] FAIL midop_accept got req_ready=%b want 0", req_ready[1]); end
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    vecCount += 2;
    if (req_ready[1] !== 1'b1) begin missCount++; $display("[TB] FAIL midop_idle got req_ready=%b want 1", req_ready[1]); end
    if (resp_valid[1] !== 1'b0) begin missCount++; $display("[TB] FAIL midop_resp_valid got %b want 0", resp_valid[1]); end
    repeat (3) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    start_req(1, ld, edges);
    vecCount++;
    if (resp_rdata[1] !== 32'h11111111) begin missCount++; $display("[TB] FAIL midop_mem got %h want 11111111", resp_rdata[1]); end
    finish_req(1);
  endtask

`ifdef MEM_STATS_EN
  // Statistics: good accesses counted, errors not, narrow counter wraps.
  task automatic test_stats();
    op_t ops[6] = '{
      '{1'b1, 8'h30, 2'b10, 1'b0, 32'h01020304, 32'h0, 1'b0},
      '{1'b1, 8'h34, 2'b10, 1'b0, 32'h05060708, 32'h0, 1'b0},
      '{1'b1, 8'h31, 2'b00, 1'b0, 32'h000000AA, 32'h0, 1'b0},
      '{1'b0, 8'h30, 2'b10, 1'b0, 32'h0,        32'h0, 1'b0},
      '{1'b0, 8'h34, 2'b01, 1'b0, 32'h0,        32'h0, 1'b0},
      '{1'b0, 8'h32, 2'b10, 1'b0, 32'h0,        32'h0, 1'b1}
    };
    op_t st = '{1'b1, 8'h40, 2'b10, 1'b0, 32'h5A5A5A5A, 32'h0, 1'b0};
    int edges;
    test_reset(0);
    for (int i = 0; i < 6; i++) begin
      start_req(0, ops[i], edges);
      finish_req(0);
    end
    vecCount += 2;
    if (wrCount0 !== 16'd3) begin missCount++; $display("[TB] FAIL stats_wr got %0d want 3", wrCount0); end
    if (rdCount0 !== 16'd2) begin missCount++; $display("[TB] FAIL stats_rd got %0d want 2", rdCount0); end
    test_reset(1);
    for (int i = 0; i < 5; i++) begin
      start_req(1, st, edges);
      finish_req(1);
    end
    vecCount += 2;
    if (wrCount1 !== 2'd1) begin missCount++; $display("[TB] FAIL stats_wrap_wr got %0d want 1", wrCount1); end
    if (rdCount1 !== 2'd0) begin missCount++; $display("[TB] FAIL stats_wrap_rd got %0d want 0", rdCount1); end
  endtask
`endif

  // Sequence all scenarios, then print the summary.
  initial begin
    vecCount  = 0;
    missCount = 0;
    latOf[0]  = LAT0;
    latOf[1]  = LAT1;
    for (int s = 0; s < NDUT; s++) begin
      rst_n[s]      = 1'b0;
      req_valid[s]  = 1'b0;
      req_we[s]     = 1'b0;
      req_addr[s]   = 8'h00;
      req_size[s]   = 2'b10;
      req_signed[s] = 1'b0;
      req_wdata[s]  = 32'd0;
      resp_ready[s] = 1'b0;
    end
    @(posedge clk); #1;
    test_reset(0);
    test_reset(1);
    test_word_rw();
    test_subword();
    test_misaligned();
    test_backpressure();
    test_reset_midop();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
